// File: rtl/spi_dma_pkg.sv
// Shared types and helpers for the SPI DMA request controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package spi_dma_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLDOFF = 2'd2
  } dma_state_e;

  // Width needed to hold a FIFO occupancy of 0..depth inclusive.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Burst request condition for one channel. Levels above depth are clamped
  // to depth (treated as full), so free space can never go negative.
  function automatic logic req_cond(input logic is_rx, input int depth,
                                    input int level, input int watermark,
                                    input int beats);
    int lvl_c;
    int free_c;
    lvl_c  = (level > depth) ? depth : level;
    free_c = depth - lvl_c;
    if (is_rx) begin
      return (lvl_c >= beats) && (lvl_c >= watermark);
    end
    return (free_c >= beats) && (lvl_c <= watermark);
  endfunction

endpackage

// File: rtl/spi_dma_ch.sv
// One DMA request channel: IDLE/REQ/HOLDOFF FSM, beat counter, sticky error.
// Latency: request 1 cycle after condition; req drops / done pulses 1 cycle after last ack.
// Backpressure: level-held req; acks may arrive back-to-back or with gaps.
// Ports: clk/rst_n; ch_en_i, fifo_level_i, watermark_i, burst_len_i (config);
//        dma_ack_i, err_clr_i (inputs); dma_req_o, burst_done_o, err_ack_o (registered).
module spi_dma_ch
  import spi_dma_pkg::*;
#(
  parameter bit IS_RX      = 1'b0,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_W    = 4,
  parameter int LVL_W      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ch_en_i,
  input  logic [LVL_W-1:0]   fifo_level_i,
  input  logic [LVL_W-1:0]   watermark_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               dma_ack_i,
  input  logic               err_clr_i,
  output logic               dma_req_o,
  output logic               burst_done_o,
  output logic               err_ack_o
);

  dma_state_e         state_q, state_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               start_ok;

  // Beats are burst_len + 1, evaluated at full integer width so the
  // maximum burst_len does not wrap.
  assign start_ok = ch_en_i &&
                    req_cond(IS_RX, FIFO_DEPTH, int'(fifo_level_i),
                             int'(watermark_i), int'(burst_len_i) + 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    // Clear first so a same-cycle spurious ack below takes priority.
    if (err_clr_i) err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dma_ack_i) err_d = 1'b1;
        if (start_ok) begin
          state_d = REQ;
          cnt_d   = burst_len_i;
        end
      end
      REQ: begin
        if (dma_ack_i) begin
          // Counter at zero marks the final beat; it never decrements past it.
          if (cnt_q == '0) begin
            state_d = HOLDOFF;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - BURST_W'(1);
          end
        end
      end
      HOLDOFF: begin
        // One dead cycle so fifo_level reflects the last beat before re-evaluation.
        if (dma_ack_i) err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dma_req_o    = req_q;
  assign burst_done_o = done_q;
  assign err_ack_o    = err_q;

endmodule

// File: rtl/spi_dma_req_ctrl.sv
// Multi-channel DMA burst request controller driven by FIFO level and watermark.
// Latency: request 1 cycle after condition; req drops / done pulses 1 cycle after last ack.
// Backpressure: per-channel level-held dma_req; independent channels, no arbitration.
// Ports: clk/rst_n; ch_en, fifo_level, watermark, burst_len (packed per channel);
//        dma_ack, err_clr (per channel); dma_req, burst_done, err_ack (registered).
module spi_dma_req_ctrl
  import spi_dma_pkg::*;
#(
  parameter  int                NUM_CH     = 2,
  parameter  logic [NUM_CH-1:0] CH_IS_RX   = 2'b10,
  parameter  int                FIFO_DEPTH = 16,
  parameter  int                BURST_W    = 4,
  localparam int                LVL_W      = lvl_width(FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH*LVL_W-1:0]   fifo_level,
  input  logic [NUM_CH*LVL_W-1:0]   watermark,
  input  logic [NUM_CH*BURST_W-1:0] burst_len,
  output logic [NUM_CH-1:0]         dma_req,
  input  logic [NUM_CH-1:0]         dma_ack,
  output logic [NUM_CH-1:0]         burst_done,
  output logic [NUM_CH-1:0]         err_ack,
  input  logic [NUM_CH-1:0]         err_clr
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    spi_dma_ch #(
      .IS_RX      (CH_IS_RX[g]),
      .FIFO_DEPTH (FIFO_DEPTH),
      .BURST_W    (BURST_W),
      .LVL_W      (LVL_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .ch_en_i      (ch_en[g]),
      .fifo_level_i (fifo_level[g*LVL_W +: LVL_W]),
      .watermark_i  (watermark[g*LVL_W +: LVL_W]),
      .burst_len_i  (burst_len[g*BURST_W +: BURST_W]),
      .dma_ack_i    (dma_ack[g]),
      .err_clr_i    (err_clr[g]),
      .dma_req_o    (dma_req[g]),
      .burst_done_o (burst_done[g]),
      .err_ack_o    (err_ack[g])
    );
  end

endmodule

// File: tb/tb_spi_dma_req_ctrl.sv
// Testbench for spi_dma_req_ctrl: directed scenarios plus randomized traffic
// checked against a beats-remaining / cooldown reference model.
// Channel 0 is TX, channel 1 is RX, FIFO depth 16, 4-bit burst length.
module tb_spi_dma_req_ctrl;

  localparam int NUM_CH  = 2;
  localparam int LVL_W   = 5;
  localparam int BURST_W = 4;
  localparam int DEPTH   = 16;
  localparam logic [NUM_CH-1:0] IS_RX = 2'b10;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_CH-1:0]         ch_en;
  logic [NUM_CH*LVL_W-1:0]   fifo_level;
  logic [NUM_CH*LVL_W-1:0]   watermark;
  logic [NUM_CH*BURST_W-1:0] burst_len;
  logic [NUM_CH-1:0]         dma_req;
  logic [NUM_CH-1:0]         dma_ack;
  logic [NUM_CH-1:0]         burst_done;
  logic [NUM_CH-1:0]         err_ack;
  logic [NUM_CH-1:0]         err_clr;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: beats still owed in the current burst, and cycles to
  // wait after a burst before the request condition is looked at again.
  int                m_rem  [NUM_CH];
  int                m_cool [NUM_CH];
  logic [NUM_CH-1:0] m_req, m_done, m_err;

  spi_dma_req_ctrl #(
    .NUM_CH     (NUM_CH),
    .CH_IS_RX   (IS_RX),
    .FIFO_DEPTH (DEPTH),
    .BURST_W    (BURST_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_en      (ch_en),
    .fifo_level (fifo_level),
    .watermark  (watermark),
    .burst_len  (burst_len),
    .dma_req    (dma_req),
    .dma_ack    (dma_ack),
    .burst_done (burst_done),
    .err_ack    (err_ack),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_cond(input int ch);
    int lvl, wm, beats, free_sp;
    lvl   = int'(fifo_level[ch*LVL_W +: LVL_W]);
    wm    = int'(watermark[ch*LVL_W +: LVL_W]);
    beats = int'(burst_len[ch*BURST_W +: BURST_W]) + 1;
    if (lvl > DEPTH) lvl = DEPTH;
    free_sp = DEPTH - lvl;
    if (IS_RX[ch]) return (lvl >= beats) && (lvl >= wm);
    return (free_sp >= beats) && (lvl <= wm);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_rem[i]  = 0;
      m_cool[i] = 0;
    end
    m_req  = '0;
    m_done = '0;
    m_err  = '0;
  endtask

  task automatic model_edge();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bit spur;
      spur = dma_ack[ch] && (m_rem[ch] == 0);
      m_done[ch] = 1'b0;
      if (m_rem[ch] > 0) begin
        if (dma_ack[ch]) begin
          m_rem[ch]--;
          if (m_rem[ch] == 0) begin
            m_done[ch] = 1'b1;
            m_cool[ch] = 1;
          end
        end
      end else if (m_cool[ch] > 0) begin
        m_cool[ch]--;
      end else if (ch_en[ch] && m_cond(ch)) begin
        m_rem[ch] = int'(burst_len[ch*BURST_W +: BURST_W]) + 1;
      end
      if (spur) m_err[ch] = 1'b1;
      else if (err_clr[ch]) m_err[ch] = 1'b0;
      m_req[ch] = (m_rem[ch] > 0);
    end
  endtask

  // Inputs change only after the falling edge; the model samples them at the
  // rising edge and outputs are compared at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input bit en, input int lvl, input int wm, input int bl);
    ch_en[ch]                       = en;
    fifo_level[ch*LVL_W +: LVL_W]   = LVL_W'(lvl);
    watermark[ch*LVL_W +: LVL_W]    = LVL_W'(wm);
    burst_len[ch*BURST_W +: BURST_W] = BURST_W'(bl);
  endtask

  task automatic clear_inputs();
    ch_en      = '0;
    fifo_level = '0;
    watermark  = '0;
    burst_len  = '0;
    dma_ack    = '0;
    err_clr    = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    set_ch(0, 1'b1, 2, 4, 3);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({dma_req, burst_done, err_ack} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_state: req/done/err=%b required 000000", {dma_req, burst_done, err_ack});
    end
    rst_n = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_tx_single();
    set_ch(0, 1'b1, 2, 4, 3);
    tick();
    vectors++;
    if (dma_req[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL tx_req_latency: dma_req0=%b required 1", dma_req[0]);
    end
    for (int i = 0; i < 4; i++) begin
      dma_ack[0] = 1'b1;
      tick();
      dma_ack[0] = 1'b0;
      vectors++;
      if ({dma_req[0], burst_done[0]} !== ((i == 3) ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL tx_ack%0d: req/done=%b%b required %b", i, dma_req[0], burst_done[0],
                 ((i == 3) ? 2'b01 : 2'b10));
      end
    end
    ch_en[0] = 1'b0;
    tick();
    vectors++;
    if ({dma_req, burst_done, err_ack} !== {m_req, m_done, m_err} || burst_done[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_done_width: req/done/err=%b required %b",
               {dma_req, burst_done, err_ack}, {m_req, m_done, m_err});
    end
    tick();
  endtask

  task automatic test_rx_threshold();
    set_ch(1, 1'b1, 3, 4, 3);
    repeat (2) tick();
    vectors++;
    if (dma_req[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_below_wm: dma_req1=%b required 0", dma_req[1]);
    end
    fifo_level[LVL_W +: LVL_W] = LVL_W'(4);
    tick();
    vectors++;
    if (dma_req[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL rx_at_wm: dma_req1=%b required 1", dma_req[1]);
    end
    for (int i = 0; i < 4; i++) begin
      dma_ack[1] = 1'b1;
      tick();
      dma_ack[1] = 1'b0;
      vectors++;
      if ({dma_req, burst_done, err_ack} !== {m_req, m_done, m_err}) begin
        miscompares++;
        $display("FAIL rx_ack%0d: req/done/err=%b required %b", i,
                 {dma_req, burst_done, err_ack}, {m_req, m_done, m_err});
      end
    end
    ch_en[1] = 1'b0;
    repeat (2) tick();
    set_ch(1, 1'b1, 4, 2, 7);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dma_req[1] !== 1'b0 || dma_req !== m_req) begin
        miscompares++;
        $display("FAIL rx_short_burst: dma_req=%b required %b (ch1 0)", dma_req, m_req);
      end
    end
    ch_en[1] = 1'b0;
  endtask

  task automatic test_spurious();
    dma_ack[0] = 1'b1;
    tick();
    dma_ack[0] = 1'b0;
    vectors++;
    if ({err_ack[0], dma_req[0]} !== 2'b10) begin
      miscompares++;
      $display("FAIL spur_set: err/req=%b%b required 10", err_ack[0], dma_req[0]);
    end
    dma_ack[0] = 1'b1;
    err_clr[0] = 1'b1;
    tick();
    dma_ack[0] = 1'b0;
    vectors++;
    if (err_ack[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL spur_set_wins: err_ack0=%b required 1", err_ack[0]);
    end
    tick();
    err_clr[0] = 1'b0;
    vectors++;
    if (err_ack[0] !== 1'b0 || err_ack !== m_err) begin
      miscompares++;
      $display("FAIL spur_clear: err_ack=%b required %b", err_ack, m_err);
    end
  endtask

  task automatic test_enable_drop();
    set_ch(0, 1'b1, 2, 4, 3);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) ch_en[0] = 1'b0;
      dma_ack[0] = 1'b1;
      tick();
      dma_ack[0] = 1'b0;
      vectors++;
      if ({dma_req[0], burst_done[0]} !== ((i == 3) ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL en_drop_ack%0d: req/done=%b%b required %b", i, dma_req[0], burst_done[0],
                 ((i == 3) ? 2'b01 : 2'b10));
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (dma_req[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL en_drop_rereq: dma_req0=%b required 0 (cycle %0d)", dma_req[0], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks, dones;
    bit prev;
    acks  = 0;
    dones = 0;
    prev  = 1'b0;
    set_ch(0, 1'b1, 2, 4, 0);
    for (int i = 0; i < 15; i++) begin
      dma_ack[0] = dma_req[0];
      if (dma_req[0]) acks++;
      tick();
      if (burst_done[0]) dones++;
      vectors++;
      if ({dma_req, burst_done, err_ack} !== {m_req, m_done, m_err} || (prev && dma_req[0])) begin
        miscompares++;
        $display("FAIL b2b_cyc%0d: req/done/err=%b required %b prev_req=%b", i,
                 {dma_req, burst_done, err_ack}, {m_req, m_done, m_err}, prev);
      end
      prev = dma_req[0];
    end
    dma_ack[0] = 1'b0;
    ch_en[0]   = 1'b0;
    vectors++;
    if (acks != 5 || dones != 5) begin
      miscompares++;
      $display("FAIL b2b_counts: acks=%0d dones=%0d required 5 and 5", acks, dones);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_burst();
    set_ch(0, 1'b1, 2, 4, 3);
    tick();
    dma_ack[0] = 1'b1;
    tick();
    dma_ack[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dma_req[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: dma_req0=%b required 0 before any clock", dma_req[0]);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (dma_req[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_req: dma_req0=%b required 1", dma_req[0]);
    end
    for (int i = 0; i < 4; i++) begin
      dma_ack[0] = 1'b1;
      tick();
      dma_ack[0] = 1'b0;
      vectors++;
      if ({dma_req, burst_done, err_ack} !== {m_req, m_done, m_err} ||
          dma_req[0] !== (i != 3)) begin
        miscompares++;
        $display("FAIL post_reset_ack%0d: req/done/err=%b required %b", i,
                 {dma_req, burst_done, err_ack}, {m_req, m_done, m_err});
      end
    end
    ch_en[0] = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        set_ch(ch, ($urandom % 4) != 0, int'($urandom_range(0, 20)),
               int'($urandom_range(0, 16)), int'($urandom_range(0, 15)));
        if (dma_req[ch]) dma_ack[ch] = ($urandom % 3) != 0;
        else             dma_ack[ch] = ($urandom % 16) == 0;
        err_clr[ch] = ($urandom % 8) == 0;
      end
      tick();
      vectors++;
      if ({dma_req, burst_done, err_ack} !== {m_req, m_done, m_err}) begin
        miscompares++;
        $display("FAIL random_cyc%0d: req/done/err=%b required %b", i,
                 {dma_req, burst_done, err_ack}, {m_req, m_done, m_err});
      end
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_rx_threshold();
    test_spurious();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_dma_req_ctrl.md
# spi_dma_req_ctrl

Multi-channel DMA request/acknowledge controller for the SPI master. It replaces fixed single-beat TX/RX handshake wiring with per-channel bursts that are driven by FIFO level and watermark. Each channel watches its FIFO fill level, raises a burst request toward the system DMA, counts acknowledged beats, and reports completion and protocol errors. It sits between the SPI master's TX/RX FIFOs and the DMA handshake interface.

## Interface

Parameters:
- NUM_CH, 2: number of independent channels.
- CH_IS_RX, 2'b10: per-channel direction bitmask. 1 = RX (drain FIFO), 0 = TX (fill FIFO).
- FIFO_DEPTH, 16: entries per channel FIFO. LVL_W = $clog2(FIFO_DEPTH+1).
- BURST_W, 4: burst length field width. Beats per burst = burst_len + 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ch_en  input  NUM_CH  per-channel enable.
- fifo_level  input  NUM_CH*LVL_W  current FIFO occupancy for each channel.
- watermark  input  NUM_CH*LVL_W  threshold. TX requests when level <= watermark; RX requests when level >= watermark.
- burst_len  input  NUM_CH*BURST_W  beats-minus-one per burst.
- dma_req  output  NUM_CH  burst request, level-held.
- dma_ack  input  NUM_CH  one-cycle pulse per transferred beat.
- burst_done  output  NUM_CH  one-cycle pulse after the final beat of a burst.
- err_ack  output  NUM_CH  sticky: an ack arrived while the channel was not in REQ.
- err_clr  input  NUM_CH  clears err_ack.

## Operation

- Channels are fully independent. There is no arbitration between channels.
- Each channel runs a per-channel FSM with states IDLE, REQ and HOLDOFF.
- IDLE → REQ when ch_en=1 and the channel's request condition holds:
  - TX: (FIFO_DEPTH − level) >= beats and level <= watermark.
  - RX: level >= beats and level >= watermark.
- On entry to REQ:
  - burst_len is sampled into the beat counter (beats−1).
  - dma_req is set.
- In REQ, each dma_ack decrements the counter.
- The ack received with counter = 0 is the last beat. On that ack:
  - dma_req clears.
  - burst_done pulses.
  - The FSM moves to HOLDOFF.
- HOLDOFF → IDLE unconditionally after one cycle. This lets fifo_level reflect the final beat before the next evaluation.
- Once a burst has started, ch_en is ignored. A deasserting ch_en takes effect only in IDLE.
- burst_len and watermark changes during REQ do not affect the burst in flight.
- A dma_ack in IDLE or HOLDOFF sets err_ack. The ack is otherwise ignored and does not change the counter or state.
- If err_clr and an error ack occur in the same cycle, set wins.
- burst_len = 2^BURST_W − 1 gives 2^BURST_W beats. The counter never wraps below 0.
- Arithmetic: free space is computed at LVL_W+1 bits so that level = FIFO_DEPTH gives 0 and never goes negative.
- Out-of-range levels (> FIFO_DEPTH) are treated as full: no TX request is made, and an RX request is allowed.

## Timing

- Reset values: dma_req = 0, burst_done = 0, err_ack = 0, every FSM in IDLE, counters = 0.
- Reset asserted mid-burst drops dma_req immediately (asynchronously). The burst is abandoned.
- All outputs are registered.
- Request latency: a condition that becomes true before edge n gives dma_req = 1 after edge n.
- dma_ack is sampled at rising edges.
- Last ack sampled at edge k:
  - dma_req = 0 after edge k.
  - burst_done = 1 for the cycle after edge k.
- Minimum dma_req low time between bursts is 2 cycles (HOLDOFF plus IDLE evaluation). The earliest re-assert is after edge k+2.
- Back-to-back acks, one per cycle, are supported. Gaps between acks are allowed.
- err_ack sets after the edge that samples the offending ack. err_clr clears after its sampling edge.

## Structure

- Package spi_dma_pkg holds:
  - dma_state_e enum (IDLE, REQ, HOLDOFF).
  - Localparam helpers for LVL_W.
  - A function computing the request condition from (is_rx, level, watermark, beats).
- Sub-module spi_dma_ch holds one channel: FSM, beat counter and error flag. The top instantiates it NUM_CH times in a generate loop and slices the packed vectors.

## Test plan

- TX single burst: FIFO_DEPTH=16, level=2, watermark=4, burst_len=3, ch_en=1 → dma_req high 1 cycle later; 4 acks → dma_req low after the 4th ack, one burst_done pulse.
- RX threshold: level=3, watermark=4 → no request; level=4, burst_len=3 → dma_req asserts. With level=4, watermark=2, burst_len=7 (8 beats) → no request.
- Spurious ack: ack in IDLE → err_ack=1, no state change. err_clr together with a new spurious ack → err_ack stays 1. err_clr alone → 0.
- Enable drop mid-burst: ch_en=0 after 2 of 4 acks → dma_req stays high until the 4th ack, then no re-request.
- Back-to-back bursts: condition held true, burst_len=0 → req pattern of 1 high, ≥2 low, repeating; burst_done pulses once per ack.
- Reset mid-burst: rst_n low during REQ → dma_req drops without a clock. After release the channel is in IDLE and a fresh full-length burst starts.
